bomb_count_selector: RTL
========================

BOMB_COUNT_SELECTOR -- requirements
Module: bomb_count_selector

Interface
REQ-001 SHALL have parameter N_SW, default 6: number of thermometer-coded selection switches.
REQ-002 SHALL have parameter MAX_CNT, default 6: largest accepted count, 1 <= MAX_CNT <= N_SW.
REQ-003 SHALL have parameter DB_CYCLES, default 4: consecutive stable cycles required before evaluation, >= 1.
REQ-004 SHALL have parameter CNT_W, default 4: count width, 2^CNT_W > N_SW.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port sw, input, N_SW bits: raw switch levels, bit 0 = first switch; already synchronised upstream.
REQ-008 SHALL have port confirm, input, 1 bit: request level; a rising edge starts a selection.
REQ-009 SHALL have port clear, input, 1 bit: level; drops any held result.
REQ-010 SHALL have port count, output, CNT_W bits: accepted count, binary.
REQ-011 SHALL have port count_valid, output, 1 bit: high while count holds an accepted result.
REQ-012 SHALL have port err, output, 1 bit: last evaluation rejected.
REQ-013 SHALL have port busy, output, 1 bit: high while in WAIT_STABLE.

Function
REQ-014 SHALL register confirm into confirm_q each cycle; rising edge = confirm & ~confirm_q.
REQ-015 SHALL register sw into sw_q each cycle; a cycle is stable when sw == sw_q.
REQ-016 SHALL implement states IDLE, WAIT_STABLE, LOCKED, all outputs registered.
REQ-017 IDLE: on confirm rising edge -> WAIT_STABLE, stab_cnt = 0, err = 0; otherwise hold.
REQ-018 WAIT_STABLE: unstable cycle -> stab_cnt = 0; stable cycle -> stab_cnt + 1; no timeout.
REQ-019 WAIT_STABLE: on a stable cycle with stab_cnt == DB_CYCLES-1, SHALL evaluate sw on that edge.
REQ-020 Valid pattern: sw == 2^k - 1 with 1 <= k <= MAX_CNT; then count = k, count_valid = 1, err = 0, -> LOCKED.
REQ-021 Invalid pattern (zero, non-thermometer, k > MAX_CNT): count = 0, count_valid = 0, err = 1, -> IDLE.
REQ-022 Latency with stable sw: result registered DB_CYCLES edges after the edge that entered WAIT_STABLE.
REQ-023 LOCKED: hold count and count_valid; ignore sw changes and confirm edges.
REQ-024 clear high in any state -> IDLE, count = 0, count_valid = 0, err = 0, stab_cnt = 0 on that edge.
REQ-025 clear SHALL take priority over a simultaneous confirm edge or evaluation; the edge is discarded.
REQ-026 err SHALL hold until next confirm rising edge or clear.
REQ-027 busy SHALL be 1 exactly while state == WAIT_STABLE.
REQ-028 stab_cnt SHALL saturate at DB_CYCLES-1 and never wrap.
REQ-029 A confirm held high continuously SHALL start only one selection.

Reset
REQ-030 rst low SHALL immediately force IDLE, count = 0, count_valid = 0, err = 0, busy = 0, stab_cnt = 0, confirm_q = 0, sw_q = 0, independent of clk.
REQ-031 Reset asserted mid-WAIT_STABLE or LOCKED SHALL abandon the operation; no result after release.
REQ-032 After release, first confirm rising edge SHALL behave as from IDLE.

Verification (defaults N_SW=6, MAX_CNT=6, DB_CYCLES=4)
REQ-033 sw=000111 stable, one-cycle confirm pulse -> busy 4 cycles, then count=3, count_valid=1, err=0, held in LOCKED.
REQ-034 sw=000101, confirm -> after 4 cycles count=0, count_valid=0, err=1, busy=0; sw=000000 gives same.
REQ-035 sw bounces 000011<->000111 for 3 cycles after confirm, then settles 000111 -> result only 4 stable cycles after settling, count=3.
REQ-036 MAX_CNT=5, sw=111111, confirm -> err=1, count=0; sw=011111 -> count=5.
REQ-037 In LOCKED count=3, clear and confirm same cycle -> IDLE, count=0, count_valid=0, no new selection; confirm held high then ignored until it falls and rises.
REQ-038 rst low 2 cycles into WAIT_STABLE -> all outputs 0 asynchronously; stable sw after release produces no result without a new confirm edge.

Source files
------------

// File: rtl/bomb_count_selector.sv
// rtl/bomb_count_selector.sv - debounced thermometer-switch count selector
//
// Purpose: on a confirm rising edge, wait until the switch bank has been
// stable for DB_CYCLES consecutive cycles, then accept the pattern as a count
// if it is a thermometer code 2^k-1 with 1 <= k <= MAX_CNT, or flag an error.
// An accepted count is held until clear.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   sw[N_SW]     raw switch levels (bit 0 = first switch), already synchronised
//   confirm      request level; its rising edge starts a selection
//   clear        level; drops any held result and returns to idle
//   count        accepted count, binary
//   count_valid  high while count holds an accepted result
//   err          last evaluation was rejected
//   busy         high while waiting for the switches to settle
module bomb_count_selector #(
  parameter int N_SW      = 6,
  parameter int MAX_CNT   = 6,
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SW-1:0]   sw,
  input  logic              confirm,
  input  logic              clear,
  output logic [CNT_W-1:0]  count,
  output logic              count_valid,
  output logic              err,
  output logic              busy
);

  localparam int STAB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_STABLE = 2'd1,
    LOCKED      = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [STAB_W-1:0]   stab_cnt, stab_cnt_nxt;
  logic                confirm_q;
  logic [N_SW-1:0]     sw_q;
  logic [CNT_W-1:0]    count_nxt;
  logic                count_valid_nxt, err_nxt, busy_nxt;

  logic                rise, stable, eval_now, thermo, pat_ok;
  logic [CNT_W-1:0]    ones;

  assign rise     = confirm & ~confirm_q;
  assign stable   = (sw == sw_q);
  assign eval_now = (state == WAIT_STABLE) && stable && (stab_cnt == STAB_LAST);

  // A thermometer code has no zero below its highest one, so adding one
  // carries into a bit that was clear; all-ones wraps to zero.
  always_comb begin
    ones = '0;
    for (int i = 0; i < N_SW; i++) begin
      ones = ones + CNT_W'(sw[i]);
    end
    thermo = (sw != '0) && ((sw & (sw + N_SW'(1))) == '0);
    pat_ok = thermo && (ones <= CNT_W'(MAX_CNT));
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      stab_cnt    <= '0;
      confirm_q   <= 1'b0;
      sw_q        <= '0;
      count       <= '0;
      count_valid <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      stab_cnt    <= stab_cnt_nxt;
      confirm_q   <= confirm;
      sw_q        <= sw;
      count       <= count_nxt;
      count_valid <= count_valid_nxt;
      err         <= err_nxt;
      busy        <= busy_nxt;
    end
  end

  // Next-state logic; clear overrides any confirm edge or evaluation
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:        if (rise) state_nxt = WAIT_STABLE;
        WAIT_STABLE: if (eval_now) state_nxt = pat_ok ? LOCKED : IDLE;
        LOCKED:      state_nxt = LOCKED;
        default:     state_nxt = IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    count_nxt       = count;
    count_valid_nxt = count_valid;
    err_nxt         = err;
    stab_cnt_nxt    = stab_cnt;
    if (clear) begin
      count_nxt       = '0;
      count_valid_nxt = 1'b0;
      err_nxt         = 1'b0;
      stab_cnt_nxt    = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            stab_cnt_nxt = '0;
            err_nxt      = 1'b0;
          end
        end
        WAIT_STABLE: begin
          if (!stable) begin
            stab_cnt_nxt = '0;
          end else if (eval_now) begin
            stab_cnt_nxt = '0;
            if (pat_ok) begin
              count_nxt       = ones;
              count_valid_nxt = 1'b1;
              err_nxt         = 1'b0;
            end else begin
              count_nxt       = '0;
              count_valid_nxt = 1'b0;
              err_nxt         = 1'b1;
            end
          end else if (stab_cnt < STAB_LAST) begin
            stab_cnt_nxt = stab_cnt + STAB_W'(1);
          end
        end
        default: ;
      endcase
    end
    busy_nxt = (state_nxt == WAIT_STABLE);
  end

endmodule
